// File: rtl/otter_iobus_uart_tx_pkg.sv
// Shared definitions for the OTTER IOBUS UART transmitter: register map,
// STATUS bit positions and the serializer state encoding.
package otter_io_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/otter_iobus_uart_tx_if.sv
// OTTER IOBUS responder-side signal bundle; the CPU is the master.
interface otter_iobus_uart_tx_if;

    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
    modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);

endinterface

// File: rtl/otter_iobus_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide at any
// fill level, including full (the pop frees the slot the push takes).
module otter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: storage has no reset; pointers and count alone define validity,
    // so the array can map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/otter_iobus_uart_tx.sv
// Memory-mapped UART transmitter on the OTTER IOBUS: TX FIFO feeding an 8N1
// serializer. Define UART_PARITY_EN to insert an even-parity bit (8E1).
module otter_iobus_uart_tx
    import otter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    otter_iobus_uart_tx_if.slave  bus,
    output logic                  TX
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel, wr_txdata, wr_status, wr_bauddiv;
    logic [1:0]    reg_idx;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          load, timer_done;
    logic          unused_bits;

    uart_state_t   state_q, state_d;
    logic [15:0]   div_q, div_d, div_lat_q, div_lat_d, timer_q, timer_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          par_q, par_d, tx_q, tx_d, ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;

    assign sel        = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign reg_idx    = bus.IOBUS_ADDR[3:2];
    assign wr_txdata  = sel && bus.IOBUS_WR && (reg_idx == REG_TXDATA);
    assign wr_status  = sel && bus.IOBUS_WR && (reg_idx == REG_STATUS);
    assign wr_bauddiv = sel && bus.IOBUS_WR && (reg_idx == REG_BAUDDIV);
    assign unused_bits = ^{bus.IOBUS_OUT[31:16], bus.IOBUS_ADDR[1:0]};

    otter_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push_i  (wr_txdata),
        .data_i  (bus.IOBUS_OUT[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        div_d   = div_q;
        ovf_d   = ovf_q;
        rdata_d = '0;
        if (wr_bauddiv) div_d = (bus.IOBUS_OUT[15:0] == 16'd0) ? 16'd1 : bus.IOBUS_OUT[15:0];
        if (wr_status && bus.IOBUS_OUT[STAT_OVF]) ovf_d = 1'b0;
        // A push into a full FIFO is only lost when no pop frees a slot this cycle.
        if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (sel) begin
            case (reg_idx)
                REG_STATUS: begin
                    rdata_d[STAT_BUSY]              = (state_q != IDLE);
                    rdata_d[STAT_FULL]              = fifo_full;
                    rdata_d[STAT_EMPTY]             = fifo_empty;
                    rdata_d[STAT_OVF]               = ovf_q;
                    rdata_d[STAT_CNT_LSB +: CW]     = fifo_count;
                end
                REG_BAUDDIV: rdata_d[15:0] = div_q;
                default: rdata_d = '0;
            endcase
        end
    end

    assign timer_done = (timer_q == 16'd1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        div_lat_d = div_lat_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_d     = par_q;
        load      = 1'b0;
        if (state_q != IDLE && !timer_done) timer_d = timer_q - 16'd1;
        case (state_q)
            IDLE:  load = !fifo_empty;
            START: if (timer_done) begin
                state_d = DATA;
                timer_d = div_lat_q;
            end
            DATA: if (timer_done) begin
                timer_d = div_lat_q;
                if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: if (timer_done) begin
                state_d = STOP;
                timer_d = div_lat_q;
            end
            STOP: if (timer_done) begin
                if (!fifo_empty) load = 1'b1;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Frame start: the divisor is sampled here so BAUDDIV writes never
        // disturb a frame already on the wire.
        if (load) begin
            state_d   = START;
            div_lat_d = div_q;
            timer_d   = div_q;
            shift_d   = fifo_dout;
            par_d     = ^fifo_dout;
            bit_d     = 3'd0;
        end
        fifo_pop = load;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before this edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            timer_q   <= 16'd1;
            div_q     <= DEFAULT_DIV;
            div_lat_q <= DEFAULT_DIV;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    assign TX           = tx_q;
    assign bus.IOBUS_IN = rdata_q;

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Self-checking bench for otter_iobus_uart_tx: directed register/timing cases
// plus randomized byte streams decoded from TX by a bit-sampling receiver.
module tb_otter_iobus_uart_tx;

    localparam logic [31:0] BASE     = 32'h1100_0100;
    localparam logic [31:0] A_TXDATA = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'd4;
    localparam logic [31:0] A_BAUD   = BASE + 32'd8;
    localparam logic [31:0] A_RSVD   = BASE + 32'd12;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int NW = 50;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    int   n_checks = 0;
    int   n_pass = 0;
    bq_t  ovq;

    otter_iobus_uart_tx_if bus();

    otter_iobus_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus),
        .TX    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        @(negedge clk);
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_WR   = 1'b0;
        @(negedge clk);
        d = bus.IOBUS_IN;
    endtask

    // Expected line level at sample i: 'lead' idle cycles, then frames of FB
    // bit slots, each slot 'div' cycles long, back to back.
    function automatic logic exp_tx(input bq_t q, input int div, input int lead, input int i);
        int slot, fr, pos;
        if (i < lead) return 1'b1;
        slot = (i - lead) / div;
        fr   = slot / FB;
        pos  = slot % FB;
        if (fr >= q.size()) return 1'b1;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return q[fr][pos-1];
        if (FB == 11 && pos == 9) return ^q[fr];
        return 1'b1;
    endfunction

    // Cycle-exact waveform and BUSY-duration check for bytes written back to back.
    task automatic wave_test(input string tag, input bq_t q, input int div);
        logic [NW-1:0] obs, expv;
        logic [31:0]   r;
        int            busy = 0;
        bus_write(A_BAUD, div);
        foreach (q[j]) bus_write(A_TXDATA, {24'd0, q[j]});
        bus.IOBUS_ADDR = A_STATUS;
        for (int k = 0; k < NW; k++) begin
            obs[k]  = tx;
            expv[k] = exp_tx(q, div, 1, q.size() - 1 + k);
            if (bus.IOBUS_IN[0]) busy++;
            @(negedge clk);
        end
        check({tag, "_wave"}, obs, expv);
        check({tag, "_busy_cycles"}, busy, q.size() * FB * div);
        repeat (4) @(negedge clk);
        bus_read(A_STATUS, r);
        check({tag, "_status_idle"}, r, 32'h4);
    endtask

    // Receiver: finds the start edge, samples each bit slot mid-period.
    task automatic rx_frame(input int div, output logic [7:0] data);
        logic [FB-1:0] bits;
        int waited = 0;
        int cur = 0;
        data = '0;
        while (tx !== 1'b0 && waited < 30 * FB * div + 100) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            check("rx_start_timeout", tx, 1'b0);
            return;
        end
        for (int p = 0; p < FB; p++) begin
            repeat (p * div + div / 2 - cur) @(negedge clk);
            cur = p * div + div / 2;
            bits[p] = tx;
        end
        data = bits[8:1];
        check("rx_stop_bit", bits[FB-1], 1'b1);
`ifdef UART_PARITY_EN
        check("rx_parity_bit", bits[9], ^bits[8:1]);
`endif
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        bq_t         q;
        int          lows;

        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_iobus_in", bus.IOBUS_IN, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        bus_read(A_STATUS, r);               check("status_after_reset", r, 32'h4);
        check("tx_idle", tx, 1'b1);
        bus_read(A_BAUD, r);                 check("bauddiv_reset", r, 32'd868);
        bus_read(A_RSVD, r);                 check("reserved_read", r, 32'h0);
        bus_read(A_TXDATA, r);               check("txdata_read", r, 32'h0);
        bus_read(BASE + 32'h7, r);           check("addr_low_bits_ignored", r, 32'h4);
        bus_read(32'h1100_0204, r);          check("unselected_read", r, 32'h0);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read(A_RSVD, r);                 check("reserved_write_ignored", r, 32'h0);
        bus_write(A_BAUD, 32'h0);
        bus_read(A_BAUD, r);                 check("bauddiv_zero_as_one", r, 32'd1);
        bus_write(A_BAUD, 32'hABCD_0007);
        bus_read(A_BAUD, r);                 check("bauddiv_low_half", r, 32'd7);

        wave_test("b55_div4", '{8'h55}, 4);
        wave_test("a1_3c_div2", '{8'hA1, 8'h3C}, 2);
        wave_test("p07_div1", '{8'h07}, 1);
        wave_test("p03_div1", '{8'h03}, 1);

        // Divisor written during a frame applies only from the next frame.
        bus_write(A_BAUD, 32'd3);
        fork
            begin
                bus_write(A_TXDATA, 32'h5A);
                bus_write(A_TXDATA, 32'hC3);
                bus_write(A_BAUD, 32'd1);
            end
            begin
                rx_frame(3, b); check("middiv_frame0", b, 8'h5A);
                rx_frame(1, b); check("middiv_frame1", b, 8'hC3);
            end
        join
        repeat (5) @(negedge clk);

        // Overflow: 10 back-to-back writes, one goes straight to the shifter.
        bus_write(A_BAUD, 32'd2);
        ovq.delete();
        for (int i = 0; i < 10; i++) ovq.push_back(8'($urandom));
        fork
            begin
                logic [31:0] s;
                for (int i = 0; i < 10; i++) bus_write(A_TXDATA, {24'd0, ovq[i]});
                bus_read(A_STATUS, s);       check("ovf_status_full", s, 32'h80B);
                bus_write(A_STATUS, 32'h8);
                bus_read(A_STATUS, s);       check("ovf_w1c", s, 32'h803);
            end
            begin
                logic [7:0] rb;
                for (int i = 0; i < 9; i++) begin
                    rx_frame(2, rb);
                    check($sformatf("ovf_rx_byte%0d", i), rb, ovq[i]);
                end
            end
        join
        lows = 0;
        for (int i = 0; i < 3 * FB * 2; i++) begin
            if (tx === 1'b0) lows++;
            @(negedge clk);
        end
        check("ovf_dropped_byte_not_sent", lows, 0);
        bus_read(A_STATUS, r);               check("ovf_status_final", r, 32'h4);

        // Randomized streams at random divisors.
        for (int rnd = 0; rnd < 6; rnd++) begin
            int div, n;
            div = $urandom_range(1, 5);
            n   = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            bus_write(A_BAUD, div);
            fork
                begin
                    foreach (q[j]) bus_write(A_TXDATA, {24'd0, q[j]});
                end
                begin
                    logic [7:0] rb;
                    for (int i = 0; i < n; i++) begin
                        rx_frame(div, rb);
                        check($sformatf("rand%0d_byte%0d", rnd, i), rb, q[i]);
                    end
                end
            join
            repeat (div + 3) @(negedge clk);
            bus_read(A_STATUS, r);
            check($sformatf("rand%0d_status", rnd), r, 32'h4);
        end

        // Reset during DATA of an all-zero byte with more bytes queued.
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'hFF);
        bus_write(A_TXDATA, 32'hFF);
        repeat (14) @(negedge clk);
        check("pre_reset_in_data", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame_tx", tx, 1'b1);
        @(negedge clk);
        check("reset_mid_frame_iobus_in", bus.IOBUS_IN, 32'h0);
        rst_n = 1'b1;
        bus.IOBUS_ADDR = A_STATUS;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        check("reset_fifo_discarded", lows, 0);
        bus_read(A_STATUS, r);               check("reset_status_after", r, 32'h4);
        bus_read(A_BAUD, r);                 check("reset_bauddiv_after", r, 32'd868);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
